// File: rtl/addsub_pkg.sv
// Shared types and constants for the multi-cycle adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple-carry adder slice. Besides the carry out it exposes the
// carry into its top bit, which the parent uses for signed overflow.
module addsub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic c;

   // Bit-serial ripple across the slice, remembering the carry entering the top bit.
   always_comb begin
      sum   = '0;
      c     = cin;
      c_msb = cin;
      for (int i = 0; i < CHUNK; i++) begin
         c_msb  = c;
         sum[i] = x[i] ^ y[i] ^ c;
         c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/multi_cycle_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, carry kept in a flop
// between slices. Valid/ready on both sides; result held until consumed.
// Optional build macro MULTI_CYCLE_ADDSUB_SAT_EN saturates res on signed overflow.
module multi_cycle_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             neg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   state_t           state, state_nxt;
   logic [WIDTH-1:0] op_a, op_b;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      shamt;
   logic [CHUNK-1:0] x_sel, y_sel, sum_c;
   logic             cout_c, c_msb_c, ovf_c, last;
   logic [WIDTH-1:0] res_upd, res_fin;

`ifdef MULTI_CYCLE_ADDSUB_SAT_EN
   localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // On overflow the final carry gives the true sign: 0 means the result is positive.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                 input logic ovf,
                                                 input logic c_fin);
      if (!ovf) return r;
      return c_fin ? S_MIN : S_MAX;
   endfunction
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Select the operand slices addressed by the chunk counter.
   always_comb begin
      shamt = 32'(cnt) * 32'(CHUNK);
      x_sel = CHUNK'(op_a >> shamt);
      y_sel = CHUNK'(op_b >> shamt);
   end

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x     (x_sel),
      .y     (y_sel),
      .cin   (carry),
      .sum   (sum_c),
      .cout  (cout_c),
      .c_msb (c_msb_c)
   );

   // Merge the new slice into res and form the final-cycle flags.
   always_comb begin
      last    = (cnt == LAST);
      ovf_c   = c_msb_c ^ cout_c;
      res_upd = (res & ~(CHUNK_MASK << shamt)) | (WIDTH'(sum_c) << shamt);
      res_fin = res_upd;
`ifdef MULTI_CYCLE_ADDSUB_SAT_EN
      if (last) res_fin = saturate(res_upd, ovf_c, cout_c);
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode: accept in IDLE, step through slices, wait for consumer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Operand latch; subtraction is folded in as inverted B with carry-in of 1.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         op_a <= a;
         op_b <= b ^ {WIDTH{opcode}};
      end
   end

   // Slice counter, carry flop, result and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         carry    <= 1'b0;
         res      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         neg      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry <= (opcode == OP_SUB);
                  cnt   <= '0;
               end
            end
            RUN: begin
               res   <= res_fin;
               carry <= cout_c;
               if (last) begin
                  cnt      <= '0;
                  cout     <= cout_c;
                  overflow <= ovf_c;
                  zero     <= (res_fin == '0);
                  neg      <= res_fin[WIDTH-1];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_addsub.sv
// Scoreboard bench: one 16-bit/4-bit instance for directed and random cases,
// plus 32-bit instances with CHUNK = 1, 8 and 32 under random traffic.
module tb_multi_cycle_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        rst_n, rst32_n;
   logic        in_valid, in_ready, opcode, out_valid, out_ready;
   logic        cout, overflow, zero, neg;
   logic [15:0] a, b, res;
   logic [19:0] q16[$];
   bit          done32[3];

   multi_cycle_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .cout(cout), .overflow(overflow), .zero(zero), .neg(neg)
   );

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit topbit(input logic [31:0] v, input int w);
      return ((v >> (w - 1)) & 32'd1) != 32'd0;
   endfunction

   // Reference: plain modular arithmetic and the textbook signed-overflow rule.
   // Returns {res[31:0], cout, overflow, zero, neg}.
   function automatic logic [35:0] model(input int w, input logic [31:0] x,
                                         input logic [31:0] y, input logic op);
      logic [63:0] mask, sum;
      logic [31:0] r;
      logic        c, o, sx, sy, sr;
      mask = (64'd1 << w) - 64'd1;
      if (op) sum = {32'd0, x} + ((~{32'd0, y}) & mask) + 64'd1;
      else    sum = {32'd0, x} + {32'd0, y};
      r  = 32'(sum & mask);
      c  = ((sum >> w) & 64'd1) != 64'd0;
      sx = topbit(x, w);
      sy = topbit(y, w);
      sr = topbit(r, w);
      o  = op ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
`ifdef MULTI_CYCLE_ADDSUB_SAT_EN
      if (o) r = sx ? 32'(64'd1 << (w - 1)) : 32'(mask >> 1);
`endif
      return {r, c, o, (r == 32'd0), topbit(r, w)};
   endfunction

   // Monitor for the 16-bit instance: every handshake must match the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q16.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected16 actual res=%h required=no output", res);
         end else begin
            check("result16", 36'({res, cout, overflow, zero, neg}), 36'(q16.pop_front()));
         end
      end
   end

   task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic op,
                         input logic [19:0] exp, input bit push);
      int n;
      a = x; b = y; opcode = op; in_valid = 1'b1; n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL accept16 actual=timeout required=in_ready");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) q16.push_back(exp);
      a = 16'($urandom); b = 16'($urandom); opcode = 1'($urandom);
   endtask

   task automatic wait_valid16(output int n);
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (!out_valid) begin
         checks++; failures++;
         $display("FAIL valid16 actual=timeout required=out_valid");
      end
   endtask

   // 32-bit instances across the chunk sizes.
   for (genvar g = 0; g < 3; g++) begin : g32
      localparam int CH = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
      logic        iv, ir, op, ov, ordy, co, ovf, z, ng;
      logic [31:0] x, y, r;
      logic [35:0] q[$];

      multi_cycle_addsub #(.WIDTH(32), .CHUNK(CH)) u_dut (
         .clk(clk), .rst_n(rst32_n), .in_valid(iv), .in_ready(ir),
         .a(x), .b(y), .opcode(op), .out_valid(ov), .out_ready(ordy),
         .res(r), .cout(co), .overflow(ovf), .zero(z), .neg(ng)
      );

      initial begin
         ordy = 1'b0;
         forever begin
            @(posedge clk); #1;
            ordy = ($urandom_range(0, 3) != 0);
         end
      end

      initial begin
         int n;
         iv = 1'b0; x = '0; y = '0; op = 1'b0;
         wait (rst32_n === 1'b1);
         for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            x = $urandom; y = $urandom; op = 1'($urandom_range(0, 1));
            if (i == 0) begin x = 32'h7FFF_FFFF; y = 32'h1; op = 1'b0; end
            if (i == 1) begin x = 32'h8000_0000; y = 32'h1; op = 1'b1; end
            if (i == 2) begin x = 32'hFFFF_FFFF; y = 32'h1; op = 1'b0; end
            iv = 1'b1; n = 0;
            @(negedge clk);
            while (!ir && n < 200) begin @(negedge clk); n++; end
            if (!ir) begin
               checks++; failures++;
               $display("FAIL accept32 chunk=%0d actual=timeout required=in_ready", CH);
            end
            @(posedge clk); #1;
            iv = 1'b0;
            q.push_back(model(32, x, y, op));
            x = $urandom; y = $urandom;
         end
         n = 0;
         while (q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
         if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain32 chunk=%0d actual=%0d pending required=0", CH, q.size());
         end
         done32[g] = 1'b1;
      end

      always @(negedge clk) begin
         if (rst32_n && ov && ordy) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected32 chunk=%0d actual res=%h required=no output", CH, r);
            end else begin
               check($sformatf("result32_c%0d", CH), {r, co, ovf, z, ng}, q.pop_front());
            end
         end
      end
   end

   initial begin
      int          n;
      logic [35:0] m;
      logic [15:0] rx, ry;
      logic        rop;
      rst_n = 1'b0; rst32_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1; rst32_n = 1'b1;
      check("reset_state", 36'({in_ready, out_valid, res, cout, overflow, zero, neg}),
            36'({1'b1, 1'b0, 16'h0000, 4'b0000}));

      // Directed corner cases: {res, cout, overflow, zero, neg}
`ifdef MULTI_CYCLE_ADDSUB_SAT_EN
      send16(16'h7FFF, 16'h0001, 1'b0, {16'h7FFF, 4'b0100}, 1'b1);
`else
      send16(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 4'b0101}, 1'b1);
`endif
      wait_valid16(n);
      send16(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 4'b1010}, 1'b1);
      wait_valid16(n);
      // 3 - 5 = -2
      send16(16'h0003, 16'h0005, 1'b1, {16'hFFFE, 4'b0001}, 1'b1);
      wait_valid16(n);
      check("latency", 36'(n), 36'(4));
`ifdef MULTI_CYCLE_ADDSUB_SAT_EN
      send16(16'h8000, 16'h0001, 1'b1, {16'h8000, 4'b1101}, 1'b1);
`else
      send16(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 4'b1100}, 1'b1);
`endif
      wait_valid16(n);

      // Reset during the second RUN cycle discards the operation.
      send16(16'h1111, 16'h2222, 1'b0, 20'h0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("reset_mid_run", 36'({in_ready, out_valid, res, cout, overflow, zero, neg}),
            36'({1'b1, 1'b0, 16'h0000, 4'b0000}));
      repeat (10) @(posedge clk);
      #1;
      check("no_output_after_reset", 36'(out_valid), 36'(0));

      // Back-pressure: result held, new request waits until after the consume edge.
      out_ready = 1'b0;
      send16(16'h1234, 16'h0101, 1'b0, {16'h1335, 4'b0000}, 1'b1);
      wait_valid16(n);
      in_valid = 1'b1; a = 16'h0F0F; b = 16'h0F0F; opcode = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check("hold", 36'({in_ready, out_valid, res, cout, overflow, zero, neg}),
               36'({1'b0, 1'b1, 16'h1335, 4'b0000}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after_consume", 36'({in_ready, out_valid}), 36'(2'b10));
      @(posedge clk); #1;
      check("accept_after_consume", 36'(in_ready), 36'(0));
      q16.push_back({16'h0000, 4'b1010});
      in_valid = 1'b0;
      wait_valid16(n);
      check("latency_after_hold", 36'(n), 36'(4));

      // Random regression on the 16-bit instance.
      for (int i = 0; i < 40; i++) begin
         rx = 16'($urandom); ry = 16'($urandom); rop = 1'($urandom_range(0, 1));
         if ((i % 8) == 0) ry = rx;
         m = model(16, {16'h0, rx}, {16'h0, ry}, rop);
         send16(rx, ry, rop, m[19:0], 1'b1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      n = 0;
      while (q16.size() != 0 && n < 500) begin @(posedge clk); n++; end
      if (q16.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain16 actual=%0d pending required=0", q16.size());
      end

      n = 0;
      while (!(done32[0] && done32[1] && done32[2]) && n < 20000) begin
         @(posedge clk); n++;
      end
      if (!(done32[0] && done32[1] && done32[2])) begin
         checks++; failures++;
         $display("FAIL random32_done actual=timeout required=complete");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
